seg7_scan_ctrl: RTL and testbench

Time-multiplexing scan controller for the four-digit seven-segment display. It holds a 16-bit packed BCD value (four nibbles) and steps through the digits one slot at a time. For each slot it presents the current nibble to the shared `BCDToLED` decoder's `x` input and drives the active-low anode lines itself; the decoder's own `an` output is left unused. New values are double-buffered and applied only at frame boundaries so the display never tears. Optional leading-zero suppression and a per-slot blanking interval suppress ghosting.

---
 rtl/seg7_scan_ctrl.sv | 123 ++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// Four-digit seven-segment scan controller: steps one digit per slot, drives active-low anodes,
// and swaps in newly loaded values only at frame boundaries so the display never tears.
module seg7_scan_ctrl #(
   parameter int REFRESH_DIV  = 100000,
   parameter int BLANK_CYCLES = 1000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic        load,
   input  logic [15:0] value_in,
   input  logic        blank_lz,
   output logic [3:0]  x_out,
   output logic [3:0]  an,
   output logic [1:0]  digit_sel,
   output logic        pending,
   output logic        frame_tick
);

   localparam int             CNT_W     = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYCLES);

   logic [CNT_W-1:0] r_cnt;
   logic [1:0]       r_digit;
   logic [15:0]      r_active;
   logic [15:0]      r_shadow;
   logic             r_pending;
   logic             r_frame_tick;
   logic             r_en;
   logic             r_blank_lz;

   logic             w_slot_end;
   logic             w_commit;
   logic             w_in_blank;
   logic             w_suppress;
   logic [3:0]       w_nib_zero;
   logic [3:0]       w_lz;
   logic [3:0]       w_an_lit;

   assign w_slot_end = enable && (r_cnt == CNT_MAX);
   assign w_commit   = w_slot_end && (r_digit == 2'd3);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt   <= '0;
         r_digit <= 2'd0;
      end else if (enable) begin
         if (r_cnt == CNT_MAX) begin
            r_cnt   <= '0;
            r_digit <= r_digit + 2'd1;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   // A load landing on the commit cycle bypasses the shadow and goes straight to the display.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_active  <= 16'h0000;
         r_shadow  <= 16'h0000;
         r_pending <= 1'b0;
      end else begin
         if (load) begin
            r_shadow <= value_in;
         end
         if (w_commit) begin
            if (load) begin
               r_active <= value_in;
            end else if (r_pending) begin
               r_active <= r_shadow;
            end
            r_pending <= 1'b0;
         end else if (load) begin
            r_pending <= 1'b1;
         end
      end
   end

   // enable and blank_lz are registered so every output depends on state only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_frame_tick <= 1'b0;
         r_en         <= 1'b0;
         r_blank_lz   <= 1'b0;
      end else begin
         r_frame_tick <= w_commit;
         r_en         <= enable;
         r_blank_lz   <= blank_lz;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_digit
         assign w_nib_zero[gi] = (r_active[gi*4 +: 4] == 4'h0);
         assign w_an_lit[gi]   = (r_digit != 2'(gi));
      end
      // A digit is a leading zero when it and every digit to its left are zero.
      assign w_lz[3] = w_nib_zero[3];
      for (gi = 1; gi < 3; gi++) begin : g_lz
         assign w_lz[gi] = w_nib_zero[gi] & w_lz[gi+1];
      end
      assign w_lz[0] = 1'b0;
   endgenerate

   assign w_in_blank = (r_cnt < BLANK_LIM);
   assign w_suppress = r_blank_lz & w_lz[r_digit];

   always_comb begin
      an = 4'b1111;
      if (r_en && !w_in_blank && !w_suppress) begin
         an = w_an_lit;
      end
   end

   assign x_out      = r_active[{r_digit, 2'b00} +: 4];
   assign digit_sel  = r_digit;
   assign pending    = r_pending;
   assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: stimulus queues the expected lit-digit cycles, a monitor
// pops and compares one entry for every cycle the DUT lights a digit.
module tb_seg7_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic        load;
   logic [15:0] value_in;
   logic        blank_lz;
   logic [3:0]  x_out;
   logic [3:0]  an;
   logic [1:0]  digit_sel;
   logic        pending;
   logic        frame_tick;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          j        = 0;
   logic [7:0]  exp_q[$];
   logic [7:0]  mon_e;

   seg7_scan_ctrl #(.REFRESH_DIV(4), .BLANK_CYCLES(1)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .load       (load),
      .value_in   (value_in),
      .blank_lz   (blank_lz),
      .x_out      (x_out),
      .an         (an),
      .digit_sel  (digit_sel),
      .pending    (pending),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
      end else begin
         $display("ok   %s: %0h (t=%0t)", name, act, $time);
      end
   endtask

   // One frame of expected lit cycles: 3 lit cycles per unsuppressed digit (slot of 4, 1 blank).
   task automatic push_frame(input logic [15:0] v, input logic [3:0] mask);
      logic [3:0] a;
      for (int d = 0; d < 4; d++) begin
         if (mask[d]) begin
            for (int k = 0; k < 3; k++) begin
               a = ~(4'b0001 << d);
               exp_q.push_back({a, v[d*4 +: 4]});
            end
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic adv(input int target);
      while (j < target) begin
         step();
         j++;
      end
   endtask

   always @(negedge clk) begin
      if (an !== 4'b1111) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL lit_unexpected: an=%b x_out=%h required an=1111", an, x_out);
         end else begin
            mon_e = exp_q.pop_front();
            if ({an, x_out} !== mon_e) begin
               n_fail++;
               $display("FAIL lit_cycle: an=%b x_out=%h required an=%b x_out=%h",
                        an, x_out, mon_e[7:4], mon_e[3:0]);
            end else begin
               $display("ok   lit_cycle: an=%b x_out=%h", an, x_out);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n    = 1'b0;
      enable   = 1'b0;
      load     = 1'b0;
      value_in = 16'h0000;
      blank_lz = 1'b0;
      repeat (3) step();
      chk("rst_an", 32'(an), 32'hF);
      rst_n = 1'b1;
      step();
      chk("rst_an_idle", 32'(an), 32'hF);
      chk("rst_x_out", 32'(x_out), 32'h0);
      chk("rst_digit_sel", 32'(digit_sel), 32'h0);
      chk("rst_pending", 32'(pending), 32'h0);
      chk("rst_frame_tick", 32'(frame_tick), 32'h0);
      step();
      chk("idle_an_dark", 32'(an), 32'hF);

      // Frame 0 shows 0000 on all digits; load 1234 during digit 1.
      push_frame(16'h0000, 4'b1111);
      enable = 1'b1;
      j = 0;
      adv(5);
      load = 1'b1; value_in = 16'h1234;
      adv(6);
      load = 1'b0;
      chk("pending_rise", 32'(pending), 32'h1);
      push_frame(16'h1234, 4'b1111);
      adv(15);
      chk("pending_hold", 32'(pending), 32'h1);
      chk("tick_before_commit", 32'(frame_tick), 32'h0);
      adv(16);
      chk("pending_commit", 32'(pending), 32'h0);
      chk("tick_commit1", 32'(frame_tick), 32'h1);
      adv(17);
      chk("tick_one_cycle", 32'(frame_tick), 32'h0);

      // Leading-zero suppression: 0042 then 0000.
      adv(20);
      blank_lz = 1'b1; load = 1'b1; value_in = 16'h0042;
      adv(21);
      load = 1'b0;
      push_frame(16'h0042, 4'b0011);
      adv(32);
      chk("tick_commit2", 32'(frame_tick), 32'h1);
      adv(36);
      load = 1'b1; value_in = 16'h0000;
      adv(37);
      load = 1'b0;
      push_frame(16'h0000, 4'b0001);

      // Overwrite before commit: only 2222 may appear.
      adv(50);
      load = 1'b1; value_in = 16'h1111;
      adv(51);
      load = 1'b0;
      chk("pending_first_load", 32'(pending), 32'h1);
      adv(55);
      load = 1'b1; value_in = 16'h2222;
      adv(56);
      load = 1'b0;
      push_frame(16'h2222, 4'b1111);

      // Load exactly on the commit cycle.
      adv(79);
      chk("pending_pre_commit", 32'(pending), 32'h0);
      load = 1'b1; value_in = 16'h5678;
      adv(80);
      load = 1'b0;
      chk("pending_direct_commit", 32'(pending), 32'h0);
      chk("tick_commit5", 32'(frame_tick), 32'h1);
      push_frame(16'h5678, 4'b1111);
      adv(88);
      chk("pending_still_low", 32'(pending), 32'h0);
      push_frame(16'h5678, 4'b1111);

      // Freeze at cnt=2 of digit 2 for 10 cycles.
      adv(106);
      enable = 1'b0;
      for (int k = 0; k < 10; k++) begin
         step();
         chk("freeze_an", 32'(an), 32'hF);
         chk("freeze_digit", 32'(digit_sel), 32'h2);
      end
      enable = 1'b1;
      step();
      chk("resume_digit2", 32'(digit_sel), 32'h2);
      step();
      chk("resume_digit3", 32'(digit_sel), 32'h3);
      j = 108;

      // Reset mid-frame with a pending value.
      push_frame(16'h5678, 4'b0011);
      adv(113);
      load = 1'b1; value_in = 16'h9ABC;
      adv(114);
      load = 1'b0;
      chk("pending_before_reset", 32'(pending), 32'h1);
      adv(121);
      rst_n = 1'b0;
      #1;
      chk("midrst_an", 32'(an), 32'hF);
      chk("midrst_x_out", 32'(x_out), 32'h0);
      chk("midrst_digit_sel", 32'(digit_sel), 32'h0);
      chk("midrst_pending", 32'(pending), 32'h0);
      chk("midrst_frame_tick", 32'(frame_tick), 32'h0);
      step();
      step();
      rst_n = 1'b1;
      push_frame(16'h0000, 4'b0001);
      for (int k = 0; k < 16; k++) begin
         step();
      end
      chk("post_rst_pending", 32'(pending), 32'h0);
      chk("post_rst_tick", 32'(frame_tick), 32'h1);
      enable = 1'b0;
      step();
      chk("post_rst_tick_low", 32'(frame_tick), 32'h0);
      step();
      step();
      chk("queue_drained", 32'(exp_q.size()), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
